// File: rtl/spi_cmd_pkg.sv
// Command IDs, frame lengths, frame byte builder and FSM state type for the
// gimbal SPI command master.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_SET_PITCH = 8'h11;
  localparam logic [7:0] CMD_GET_PITCH = 8'h12;
  localparam logic [7:0] CMD_SET_YAW   = 8'h21;
  localparam logic [7:0] CMD_GET_YAW   = 8'h22;
  localparam logic [7:0] CMD_LED       = 8'h31;

  localparam logic [2:0] LEN_SHORT = 3'd1;
  localparam logic [2:0] LEN_SET   = 3'd4;
  localparam logic [2:0] LEN_GET   = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_GAP      = 3'd3,
    ST_CS_HOLD  = 3'd4,
    ST_CS_IDLE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [7:0]  id;
    logic        dir;
    logic [13:0] pwm;
  } cmd_t;

  function automatic logic is_set(input logic [7:0] id);
    return (id == CMD_SET_PITCH) || (id == CMD_SET_YAW);
  endfunction

  function automatic logic is_get(input logic [7:0] id);
    return (id == CMD_GET_PITCH) || (id == CMD_GET_YAW);
  endfunction

  function automatic logic is_known(input logic [7:0] id);
    return is_set(id) || is_get(id) || (id == CMD_RESET) || (id == CMD_LED);
  endfunction

  function automatic logic [2:0] frame_len(input logic [7:0] id);
    if (is_set(id))      return LEN_SET;
    else if (is_get(id)) return LEN_GET;
    else                 return LEN_SHORT;
  endfunction

  // GET payload bytes are zero padding clocked out while the slave answers
  function automatic logic [7:0] frame_byte(input cmd_t c, input logic [1:0] idx);
    case (idx)
      2'd0:    return c.id;
      2'd1:    return is_set(c.id) ? {7'b0, c.dir} : 8'h00;
      2'd2:    return is_set(c.id) ? {2'b0, c.pwm[13:8]} : 8'h00;
      default: return c.pwm[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One 8-bit full-duplex SPI mode-0 transfer: CLK_DIV cycles low then CLK_DIV
// high per bit, MOSI shifted on the falling edge, MISO sampled on the rising edge.
module spi_byte_xfer #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);
  localparam int DW = $clog2(CLK_DIV + 1);

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr;
  logic          phase_end;

  assign phase_end = active && (div_cnt == DW'(CLK_DIV - 1));
  // done marks the last cycle of bit 7's high phase so the caller can
  // chain the next state on the same edge as the final falling edge
  assign done      = phase_end && sclk && (bit_cnt == 3'd7);
  assign mosi      = tx_sr[7];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_byte <= '0;
      sclk    <= 1'b0;
    end else if (!active) begin
      if (start) begin
        active  <= 1'b1;
        tx_sr   <= tx_byte;
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
      end
    end else begin
      div_cnt <= phase_end ? '0 : div_cnt + DW'(1);
      if (phase_end) begin
        if (!sclk) begin
          sclk    <= 1'b1;
          rx_byte <= {rx_byte[6:0], miso};
        end else begin
          sclk    <= 1'b0;
          tx_sr   <= {tx_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/spi_cmd_master.sv
// Gimbal SPI command master: frames one latched command around spi_byte_xfer.
// Define SPI_CMD_MASTER_CMD_CHECK_EN to reject unknown command IDs with cmd_err.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_id,
  input  logic        cmd_dir,
  input  logic [13:0] cmd_pwm,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        cmd_err,
  output logic        busy,
  output logic        SPI_CLK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);
  localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_t        state;
  cmd_t          cmd;
  logic [CW-1:0] cnt;
  logic [1:0]    byte_idx;
  logic [15:0]   rx_acc, rsp_q;
  logic          rsp_vld_q;
  logic          x_start, x_done, x_mosi;
  logic [7:0]    x_rx, cur_byte;
  logic          accept, reject, last_byte;

  assign accept    = cmd_valid && cmd_ready;
  assign cur_byte  = frame_byte(cmd, byte_idx);
  assign last_byte = ({1'b0, byte_idx} == frame_len(cmd.id) - 3'd1);
  assign x_start   = ((state == ST_CS_SETUP) && (cnt == CW'(CLK_DIV - 1))) ||
                     ((state == ST_GAP)      && (cnt == CW'(GAP_CYCLES - 1)));

`ifdef SPI_CMD_MASTER_CMD_CHECK_EN
  logic err_q;
  assign reject  = !is_known(cmd_id);
  assign cmd_err = err_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= accept && reject;
  end
`else
  assign reject  = 1'b0;
  assign cmd_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cmd       <= '0;
      cnt       <= '0;
      byte_idx  <= '0;
      rx_acc    <= '0;
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      rsp_vld_q <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          cmd <= '{id: cmd_id, dir: cmd_dir, pwm: cmd_pwm};
          if (!reject) begin
            state    <= ST_CS_SETUP;
            cnt      <= '0;
            byte_idx <= '0;
          end
        end
        ST_CS_SETUP, ST_GAP: begin
          cnt <= cnt + CW'(1);
          if (x_start) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end
        end
        ST_SHIFT: if (x_done) begin
          // GET reply occupies bytes 1-2; byte 0 is the slave's don't-care
          if (is_get(cmd.id) && (byte_idx != 2'd0)) rx_acc <= {rx_acc[7:0], x_rx};
          cnt <= '0;
          if (last_byte) state <= ST_CS_HOLD;
          else begin
            state    <= ST_GAP;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        ST_CS_HOLD: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(CLK_DIV - 1)) begin
            state <= ST_CS_IDLE;
            cnt   <= '0;
          end
        end
        ST_CS_IDLE: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(CLK_DIV - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (is_get(cmd.id)) begin
              rsp_vld_q <= 1'b1;
              rsp_q     <= rx_acc;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .start   (x_start),
    .tx_byte (cur_byte),
    .done    (x_done),
    .rx_byte (x_rx),
    .sclk    (SPI_CLK),
    .mosi    (x_mosi),
    .miso    (SPI_MISO)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = rsp_vld_q;
  assign rsp_data  = rsp_q;
  assign SPI_CS    = !((state == ST_CS_SETUP) || (state == ST_SHIFT) ||
                       (state == ST_GAP) || (state == ST_CS_HOLD));
  // Outside SHIFT, present the next byte's MSB ahead of its first rising edge
  assign SPI_MOSI  = (state == ST_SHIFT) ? x_mosi :
                     ((state == ST_CS_SETUP) || (state == ST_GAP)) ? cur_byte[7] : 1'b0;

endmodule

// File: doc/spi_cmd_master.md
SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SPI_CLK half-period in CLK cycles (>=2).
REQ-002 Parameter GAP_CYCLES, default 8: SPI_CLK-low idle gap between bytes in CLK cycles (>=1).
REQ-003 CLK  input  1  system clock, the single clock domain; all logic on its rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready.
REQ-007 cmd_id  input  8  command byte: 0xFF reset, 0x11 set pitch, 0x12 get pitch, 0x21 set yaw, 0x22 get yaw, 0x31 toggle LED.
REQ-008 cmd_dir  input  1  direction bit for 0x11/0x21.
REQ-009 cmd_pwm  input  14  duty value for 0x11/0x21.
REQ-010 rsp_valid  output  1  one-cycle pulse when a GET frame completes.
REQ-011 rsp_data  output  16  count read by the last GET, MSB first; held until the next GET completes.
REQ-012 cmd_err  output  1  one-cycle pulse on a rejected command (see REQ-030).
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 SPI_CLK  output  1  serial clock, mode 0 (idle low).
REQ-015 SPI_CS  output  1  chip select, active low.
REQ-016 SPI_MOSI  output  1  serial data to the gimbal slave.
REQ-017 SPI_MISO  input  1  serial data from the gimbal slave.

Function
REQ-018 cmd_id, cmd_dir and cmd_pwm are latched on acceptance, and the frame is built only from these latched values.
REQ-019 Frame length: 0xFF/0x31 = 1 byte; 0x11/0x21 = 4 bytes {cmd_id, {7'b0,dir}, {2'b0,pwm[13:8]}, pwm[7:0]}; 0x12/0x22 = 3 bytes {cmd_id, 0x00, 0x00}.
REQ-020 States are IDLE -> CS_SETUP -> SHIFT -> (GAP -> SHIFT)* -> CS_HOLD -> CS_IDLE -> IDLE.
REQ-021 CS_SETUP: SPI_CS drives low, SPI_MOSI drives the MSB of byte 0, and SPI_CLK stays low for CLK_DIV cycles.
REQ-022 SHIFT: each bit is CLK_DIV cycles with SPI_CLK low followed by CLK_DIV cycles with SPI_CLK high; SPI_MOSI changes only on the SPI_CLK falling edge or during the low phase; each byte is sent MSB first, 16*CLK_DIV cycles per byte.
REQ-023 SPI_MISO is sampled in the CLK cycle of each SPI_CLK rising edge; in GET frames bytes 1-2 are shifted into a 16-bit register MSB first.
REQ-024 GAP: SPI_CS stays low and SPI_CLK stays low for GAP_CYCLES cycles.
REQ-025 SPI_CS is never raised mid-frame.
REQ-026 CS_HOLD: after the last falling edge, SPI_CLK stays low for CLK_DIV cycles, then SPI_CS rises.
REQ-027 CS_IDLE: SPI_CS stays high for at least CLK_DIV cycles before IDLE.
REQ-028 For a GET frame, rsp_data updates and rsp_valid pulses in the cycle of the transition to IDLE.
REQ-029 A cmd_valid held high during busy is ignored until IDLE; back-to-back commands are separated by the CS_IDLE time only.
REQ-030 Unknown cmd_id handling is set by REQ-036/037.
REQ-031 Bit and byte counters wrap to 0 at the start of each frame; no counter overflows for any legal parameter.

Reset
REQ-032 While RST_N=0 at a CLK edge: state=IDLE, SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, rsp_valid=0, cmd_err=0, busy=0, rsp_data=0, and all counters are 0.
REQ-033 cmd_ready=1 from the first cycle after reset release.
REQ-034 Reset asserted mid-frame aborts the frame with SPI_CS high at the next edge; no rsp_valid pulse is produced.

Configuration
REQ-035 Macro SPI_CMD_MASTER_CMD_CHECK_EN.
REQ-036 With SPI_CMD_MASTER_CMD_CHECK_EN defined: an unknown cmd_id is accepted, pulses cmd_err one cycle later, and produces no SPI activity.
REQ-037 Without SPI_CMD_MASTER_CMD_CHECK_EN: an unknown cmd_id is sent as a 1-byte frame, and cmd_err is tied to 0.

Structure
REQ-038 Package spi_cmd_pkg holds the command ID constants, per-command frame lengths, and the state enumeration typedef.
REQ-039 Sub-module spi_byte_xfer performs one 8-bit full-duplex mode-0 transfer (start/done handshake, CLK_DIV parameter); spi_cmd_master sequences the frame around it.

Verification
REQ-040 CLK_DIV=2: 0x11, dir=1, pwm=0x1234 -> MOSI bytes 11 01 12 34, 32 SPI_CLK rising edges, SPI_CS low continuously, no rsp_valid.
REQ-041 0x22 with the slave model returning 0xBEEF -> MOSI bytes 22 00 00, 24 rising edges, rsp_valid pulses once with rsp_data=0xBEEF.
REQ-042 0xFF, then 0x31 with cmd_valid held high -> two 8-edge frames, SPI_CS high for >=CLK_DIV cycles between them.
REQ-043 cmd_id=0x55 -> with the macro defined: cmd_err pulse and SPI_CS stays 1; without the macro: one 8-edge frame sending 0x55.
REQ-044 RST_N=0 during byte 2 of 0x12 -> SPI_CS=1, SPI_CLK=0 at the next edge, no rsp_valid, cmd_ready=1 after release.
REQ-045 CLK_DIV=4, GAP_CYCLES=8 -> each byte lasts 64 cycles and each inter-byte SPI_CLK-low gap is 8 cycles.
